i2c_arbiter: RTL and testbench
==============================

// Module: i2c_arbiter
// PURPOSE
//   Shares the single i2c_master between two requesters (client 0: camera, client 1: spare peripheral/config).
//   Round-robin grant, one whole I2C transaction per grant, fixed guard gap between transactions.
//   Latches addr/rw/packets per transaction; routes data and handshake strobes to the granted client only.
// PARAMETERS
//   GUARD_CYCLES   100     idle clk cycles after each transaction before next grant (>=1)
//   LAUNCH_TIMEOUT 255     max cycles m_start held without m_ready falling before error
//   BUSY_TIMEOUT   2000000 max cycles in BUSY before error
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   req            in   2   per-client bus request, level; bit i = client i
//   cli_addr       in   14  {c1,c0} 7-bit I2C device address
//   cli_rw         in   2   per-client rw (1 = read)
//   cli_packets    in   10  {c1,c0} 5-bit byte count
//   cli_data       in   16  {c1,c0} write byte, live (updated by client on its data_req)
//   gnt            out  2   one-hot grant, 0 when no owner
//   done           out  2   1-cycle pulse to owner at transaction end
//   cli_data_req   out  2   m_data_req gated to owner
//   cli_data_ready out  2   m_data_ready gated to owner
//   err            out  1   sticky timeout flag, cleared only by reset
//   m_start        out  1   to i2c_master start
//   m_addr         out  7   to i2c_master addr (latched)
//   m_rw           out  1   to i2c_master rw (latched)
//   m_packets      out  5   to i2c_master packets (latched)
//   m_data         out  8   to i2c_master data = cli_data of owner (combinational mux)
//   m_ready        in   1   i2c_master ready
//   m_data_req     in   1   i2c_master data_req
//   m_data_ready   in   1   i2c_master data_ready (read data taken by clients from i2c_master data_out directly)
// BEHAVIOUR
//   Reset: state IDLE, gnt=0, done=0, err=0, m_start=0, m_addr=0, m_rw=1, m_packets=0, last=1 (client 0 wins first).
//   IDLE: if m_ready=1 and req!=0 -> pick winner: sole requester, or if both, the one != last.
//     Same edge: gnt<=onehot(winner), owner<=winner, latch m_addr/m_rw/m_packets from owner, m_start<=1, -> LAUNCH.
//     m_ready=0 in IDLE (master busy/resetting): no grant.
//   LAUNCH: hold m_start=1; when m_ready=0 -> m_start<=0, -> BUSY. Count > LAUNCH_TIMEOUT -> err<=1, m_start<=0, -> GUARD.
//   BUSY: when m_ready=1 -> done[owner] pulses 1 cycle, gnt<=0, last<=owner, -> GUARD.
//     Count > BUSY_TIMEOUT -> err<=1, gnt<=0, no done, -> GUARD.
//   GUARD: count GUARD_CYCLES cycles, then -> IDLE. No grant possible here.
//   Timeout counters clear on every state entry.
//   m_data, cli_data_req, cli_data_ready: combinational from owner; all-zero when gnt=0.
//   req drop mid-transaction: ignored, transaction runs to completion (I2C cannot abort); done still pulses.
//   req held after done: treated as a new request at next IDLE (subject to round-robin).
//   Changes to cli_addr/rw/packets after grant: no effect until next grant.
//   Minimum grant-to-grant spacing: transaction + GUARD_CYCLES + 1.
//   Reset mid-operation: immediate return to reset values; i2c_master shares reset.
// TESTING
//   Client 0 alone, addr 0x58 rw=0 packets=2 data 0x30,0x01 -> gnt=01, master sees 0x58/0/2, bytes in order, done[0] 1 cycle.
//   Both req on same cycle after reset -> client 0 first, then after guard client 1; repeat -> strict alternation 0,1,0,1.
//   Client 1 read packets=16 -> cli_data_ready[1] pulses 16x, cli_data_ready[0] stays 0, m_data=0x00 when gnt=0.
//   Change cli_addr[0] to 0x21 while BUSY -> m_addr stays 0x58 until next grant.
//   Master model never drops ready -> err=1 after LAUNCH_TIMEOUT+1 cycles, gnt=0, no done; err stays 1 until reset.
//   Assert reset during BUSY -> gnt=0, m_start=0, err=0 same cycle; after release client 0 wins first.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Signal bundle between the two I2C clients, the arbiter and the shared i2c_master.
// The master modport is the arbiter's view; the slave modport is the clients' and master's view.
interface i2c_arbiter_if;
  // Handshakes:
  //   req/gnt: req[i] is a level held by client i. gnt is one-hot and lasts one whole I2C transaction.
  //     A drop of req while granted is ignored. done[i] pulses for one cycle as the grant ends.
  //   m_start/m_ready: m_start rises only while m_ready=1. It is held until m_ready falls.
  //     The transaction then runs until m_ready rises again.
  //   data strobes: m_data_req/m_data_ready reach only the owner.
  //     The owner refreshes its cli_data byte after each data_req pulse.
  logic [1:0]  req;
  logic [13:0] cli_addr;
  logic [1:0]  cli_rw;
  logic [9:0]  cli_packets;
  logic [15:0] cli_data;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [1:0]  cli_data_req;
  logic [1:0]  cli_data_ready;
  logic        err;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [4:0]  m_packets;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        m_data_req;
  logic        m_data_ready;

  modport master (
    input  req, cli_addr, cli_rw, cli_packets, cli_data,
    input  m_ready, m_data_req, m_data_ready,
    output gnt, done, cli_data_req, cli_data_ready, err,
    output m_start, m_addr, m_rw, m_packets, m_data
  );

  modport slave (
    output req, cli_addr, cli_rw, cli_packets, cli_data,
    output m_ready, m_data_req, m_data_ready,
    input  gnt, done, cli_data_req, cli_data_ready, err,
    input  m_start, m_addr, m_rw, m_packets, m_data
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin owner selection for one shared i2c_master, one whole transaction per grant.
// A fixed guard gap follows each transaction. Timeouts set a sticky err flag.
module i2c_arbiter #(
  parameter int GUARD_CYCLES   = 100,
  parameter int LAUNCH_TIMEOUT = 255,
  parameter int BUSY_TIMEOUT   = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  i2c_arbiter_if.master bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, BUSY = 2'd2, GUARD = 2'd3} state_e;

  localparam logic [31:0] LAUNCH_LIM = 32'(LAUNCH_TIMEOUT);
  localparam logic [31:0] BUSY_LIM   = 32'(BUSY_TIMEOUT);
  localparam logic [31:0] GUARD_LIM  = 32'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        m_start_q, m_start_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [4:0]  pk_q, pk_d;
  logic        winner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      rw_q      <= 1'b1;
      pk_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      pk_q      <= pk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = err_q;
    m_start_d = m_start_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    pk_d      = pk_q;
    // With both requesting, the client that did not finish last goes next.
    winner    = (bus.req == 2'b10) ? 1'b1 : (bus.req == 2'b11) ? ~last_q : 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.m_ready && (bus.req != 2'b00)) begin
          state_d   = LAUNCH;
          owner_d   = winner;
          gnt_d     = winner ? 2'b10 : 2'b01;
          addr_d    = winner ? bus.cli_addr[13:7] : bus.cli_addr[6:0];
          rw_d      = winner ? bus.cli_rw[1] : bus.cli_rw[0];
          pk_d      = winner ? bus.cli_packets[9:5] : bus.cli_packets[4:0];
          m_start_d = 1'b1;
        end
      end
      LAUNCH: begin
        if (!bus.m_ready) begin
          state_d   = BUSY;
          cnt_d     = '0;
          m_start_d = 1'b0;
        end else if (cnt_q >= LAUNCH_LIM) begin
          state_d   = GUARD;
          cnt_d     = '0;
          m_start_d = 1'b0;
          gnt_d     = '0;
          err_d     = 1'b1;
        end
      end
      BUSY: begin
        if (bus.m_ready) begin
          state_d = GUARD;
          cnt_d   = '0;
          done_d  = gnt_q;
          gnt_d   = '0;
          last_d  = owner_q;
        end else if (cnt_q >= BUSY_LIM) begin
          state_d = GUARD;
          cnt_d   = '0;
          gnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q >= GUARD_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt            = gnt_q;
    bus.done           = done_q;
    bus.err            = err_q;
    bus.m_start        = m_start_q;
    bus.m_addr         = addr_q;
    bus.m_rw           = rw_q;
    bus.m_packets      = pk_q;
    bus.m_data         = '0;
    if (gnt_q != 2'b00) bus.m_data = owner_q ? bus.cli_data[15:8] : bus.cli_data[7:0];
    bus.cli_data_req   = gnt_q & {2{bus.m_data_req}};
    bus.cli_data_ready = gnt_q & {2{bus.m_data_ready}};
    dbg_state          = state_q;
  end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: a vector table of grant scenarios plus hand sequences
// for alternation, address latching, launch timeout and reset during BUSY.
module tb_i2c_arbiter;
  localparam int G  = 8;
  localparam int LT = 20;
  localparam int BT = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  i2c_arbiter_if bus();

  i2c_arbiter #(.GUARD_CYCLES(G), .LAUNCH_TIMEOUT(LT), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit mdl_stuck = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];
  logic [7:0] tx_q0[$];
  logic [7:0] tx_q1[$];
  int done_cnt[2];
  int rdy_cnt[2];
  int dreq_cnt[2];
  int idle_bad;

  typedef struct {
    logic [1:0] req;
    logic [6:0] addr0, addr1;
    logic       rw0, rw1;
    logic [4:0] pk0, pk1;
    logic [7:0] d0, d1;
    logic [1:0] exp_gnt;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk); n++;
      if (bus.gnt != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk); n++;
      if (bus.done != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk); n++;
      if (dbg_state == s) ok = 1'b1;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; rdy_cnt[i] = 0; dreq_cnt[i] = 0;
    end
    idle_bad = 0;
  endtask

  // Winner's write bytes go both to its client queue and to the expected queue.
  task automatic load_bytes(input bit win, input logic [4:0] pk, input logic rw,
                            input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] b;
    tx_q0.delete(); tx_q1.delete(); exp_q.delete(); seen_q.delete();
    bus.cli_data = 16'hA5C3;
    if (!rw) begin
      for (int k = 0; k < int'(pk); k++) begin
        b = (k == 0) ? d0 : (k == 1) ? d1 : 8'(8'h40 + k);
        exp_q.push_back(b);
        if (win) tx_q1.push_back(b); else tx_q0.push_back(b);
      end
      if (win && tx_q1.size() > 0) bus.cli_data[15:8] = tx_q1.pop_front();
      if (!win && tx_q0.size() > 0) bus.cli_data[7:0] = tx_q0.pop_front();
    end
  endtask

  // i2c_master model: drops ready after start, one strobe per byte on odd cycles, then ready.
  initial begin : master_model
    bit in_txn; bit t_rw; int left; int ph;
    in_txn = 1'b0; t_rw = 1'b0; left = 0; ph = 0;
    bus.m_ready = 1'b1; bus.m_data_req = 1'b0; bus.m_data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.m_data_req = 1'b0; bus.m_data_ready = 1'b0;
      if (reset) begin
        in_txn = 1'b0; bus.m_ready = 1'b1;
      end else if (!in_txn) begin
        if (bus.m_start && !mdl_stuck) begin
          in_txn = 1'b1; bus.m_ready = 1'b0; t_rw = bus.m_rw;
          left = int'(bus.m_packets); ph = 0;
        end
      end else begin
        ph++;
        if (left > 0) begin
          if (ph % 2 == 1) begin
            if (t_rw) bus.m_data_ready = 1'b1;
            else begin
              seen_q.push_back(bus.m_data);
              bus.m_data_req = 1'b1;
            end
            left--;
          end
        end else if (ph % 2 == 0) begin
          in_txn = 1'b0; bus.m_ready = 1'b1;
        end
      end
    end
  end

  initial begin : client_drv
    forever begin
      @(negedge clk);
      if (bus.cli_data_req[0]) begin
        if (tx_q0.size() > 0) bus.cli_data[7:0] = tx_q0.pop_front();
        else bus.cli_data[7:0] = 8'h00;
      end
      if (bus.cli_data_req[1]) begin
        if (tx_q1.size() > 0) bus.cli_data[15:8] = tx_q1.pop_front();
        else bus.cli_data[15:8] = 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus.done[i]) done_cnt[i]++;
      if (bus.cli_data_ready[i]) rdy_cnt[i]++;
      if (bus.cli_data_req[i]) dreq_cnt[i]++;
    end
    if (bus.gnt == 2'b00 && (bus.m_data != 8'h00 || bus.cli_data_req != 2'b00 ||
        bus.cli_data_ready != 2'b00)) idle_bad++;
  end

  initial begin : main
    vec_t t; bit win; bit ok; int n;
    logic [4:0] pk; logic rw; logic [6:0] ad;
    logic [1:0] alt_exp[4];

    bus.req = '0; bus.cli_addr = '0; bus.cli_rw = '0; bus.cli_packets = '0; bus.cli_data = '0;
    clear_counts();

    // Round-robin history carries across rows; last=1 after reset so client 0 wins first.
    vecs[0] = '{2'b11, 7'h58, 7'h3C, 1'b0, 1'b1, 5'd2,  5'd16, 8'h30, 8'h01, 2'b01};
    vecs[1] = '{2'b11, 7'h58, 7'h3C, 1'b0, 1'b1, 5'd2,  5'd16, 8'h00, 8'h00, 2'b10};
    vecs[2] = '{2'b11, 7'h50, 7'h3C, 1'b0, 1'b1, 5'd3,  5'd16, 8'hAA, 8'h55, 2'b01};
    vecs[3] = '{2'b11, 7'h50, 7'h11, 1'b0, 1'b0, 5'd3,  5'd1,  8'h7E, 8'h00, 2'b10};
    vecs[4] = '{2'b01, 7'h58, 7'h11, 1'b0, 1'b0, 5'd2,  5'd1,  8'h30, 8'h01, 2'b01};
    vecs[5] = '{2'b01, 7'h22, 7'h11, 1'b1, 1'b0, 5'd4,  5'd1,  8'h00, 8'h00, 2'b01};
    vecs[6] = '{2'b10, 7'h22, 7'h7F, 1'b1, 1'b1, 5'd4,  5'd31, 8'h00, 8'h00, 2'b10};
    vecs[7] = '{2'b10, 7'h22, 7'h00, 1'b1, 1'b0, 5'd4,  5'd1,  8'hFF, 8'h00, 2'b10};

    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_m_start", bus.m_start, 1'b0);
    chk("rst_m_addr", bus.m_addr, 7'h00);
    chk("rst_m_rw", bus.m_rw, 1'b1);
    chk("rst_m_packets", bus.m_packets, 5'd0);
    chk("rst_m_data", bus.m_data, 8'h00);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      t = vecs[v];
      win = t.exp_gnt[1];
      pk = win ? t.pk1 : t.pk0;
      rw = win ? t.rw1 : t.rw0;
      ad = win ? t.addr1 : t.addr0;
      @(negedge clk);
      bus.cli_addr = {t.addr1, t.addr0};
      bus.cli_rw = {t.rw1, t.rw0};
      bus.cli_packets = {t.pk1, t.pk0};
      load_bytes(win, pk, rw, t.d0, t.d1);
      clear_counts();
      bus.req = t.req;
      wait_gnt(n, ok);
      chk($sformatf("v%0d_gnt_seen", v), ok, 1'b1);
      chk($sformatf("v%0d_gnt", v), bus.gnt, t.exp_gnt);
      chk($sformatf("v%0d_m_addr", v), bus.m_addr, ad);
      chk($sformatf("v%0d_m_rw", v), bus.m_rw, rw);
      chk($sformatf("v%0d_m_packets", v), bus.m_packets, pk);
      chk($sformatf("v%0d_m_start", v), bus.m_start, 1'b1);
      bus.req = 2'b00;
      wait_done(n, ok);
      chk($sformatf("v%0d_done_seen", v), ok, 1'b1);
      chk($sformatf("v%0d_done", v), bus.done, t.exp_gnt);
      chk($sformatf("v%0d_gnt_at_done", v), bus.gnt, 2'b00);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_done_width", v), done_cnt[win], 1);
      chk($sformatf("v%0d_done_other", v), done_cnt[!win], 0);
      chk($sformatf("v%0d_rdy_owner", v), rdy_cnt[win], rw ? int'(pk) : 0);
      chk($sformatf("v%0d_rdy_other", v), rdy_cnt[!win], 0);
      chk($sformatf("v%0d_dreq_owner", v), dreq_cnt[win], rw ? 0 : int'(pk));
      chk($sformatf("v%0d_dreq_other", v), dreq_cnt[!win], 0);
      chk($sformatf("v%0d_wbytes", v), seen_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        if (k < seen_q.size()) chk($sformatf("v%0d_wdata%0d", v, k), seen_q[k], exp_q[k]);
      chk($sformatf("v%0d_idle_gating", v), idle_bad, 0);
      chk($sformatf("v%0d_err", v), bus.err, 1'b0);
    end

    // Held requests alternate strictly; each new grant comes G+1 cycles after done.
    alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
    bus.cli_rw = 2'b00; bus.cli_packets = {5'd1, 5'd1};
    load_bytes(1'b0, 5'd0, 1'b1, 8'h00, 8'h00);
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n, ok);
      chk("alt_gnt_seen", ok, 1'b1);
      if (k > 0) chk($sformatf("alt_spacing%0d", k), n, G + 1);
      chk($sformatf("alt_gnt%0d", k), bus.gnt, alt_exp[k]);
      wait_done(n, ok);
      chk("alt_done_seen", ok, 1'b1);
    end
    bus.req = 2'b00;

    // Address change while BUSY must not reach m_addr before the next grant.
    repeat (G + 2) @(negedge clk);
    bus.cli_addr = {7'h3C, 7'h58}; bus.cli_rw = 2'b00; bus.cli_packets = {5'd1, 5'd4};
    bus.req = 2'b01;
    wait_gnt(n, ok);
    chk("latch_gnt", bus.gnt, 2'b01);
    wait_state(2'd2, ok);
    chk("latch_busy_seen", ok, 1'b1);
    bus.cli_addr[6:0] = 7'h21;
    @(negedge clk);
    chk("latch_addr_busy", bus.m_addr, 7'h58);
    wait_done(n, ok);
    chk("latch_addr_done", bus.m_addr, 7'h58);
    wait_gnt(n, ok);
    chk("latch_regrant", bus.gnt, 2'b01);
    chk("latch_addr_new", bus.m_addr, 7'h21);
    bus.req = 2'b00;
    wait_done(n, ok);

    // Master never drops ready: err after LT+1 cycles, grant withdrawn, no done, err sticky.
    repeat (G + 2) @(negedge clk);
    mdl_stuck = 1'b1;
    clear_counts();
    bus.req = 2'b01;
    wait_gnt(n, ok);
    chk("stuck_m_start", bus.m_start, 1'b1);
    n = 0;
    while (n < 300 && bus.err !== 1'b1) begin
      @(negedge clk); n++;
    end
    chk("stuck_launch_cycles", n, LT + 1);
    chk("stuck_err", bus.err, 1'b1);
    chk("stuck_gnt", bus.gnt, 2'b00);
    chk("stuck_m_start_off", bus.m_start, 1'b0);
    bus.req = 2'b00;
    repeat (50) @(negedge clk);
    chk("stuck_err_sticky", bus.err, 1'b1);
    chk("stuck_no_done", done_cnt[0] + done_cnt[1], 0);
    mdl_stuck = 1'b0;

    // Reset while BUSY clears everything at once, and client 0 wins first afterwards.
    bus.cli_rw = 2'b10; bus.cli_packets = {5'd16, 5'd2};
    bus.req = 2'b10;
    wait_gnt(n, ok);
    chk("rstb_gnt", bus.gnt, 2'b10);
    wait_state(2'd2, ok);
    chk("rstb_busy_seen", ok, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstb_gnt_clr", bus.gnt, 2'b00);
    chk("rstb_m_start", bus.m_start, 1'b0);
    chk("rstb_err_clr", bus.err, 1'b0);
    chk("rstb_m_rw", bus.m_rw, 1'b1);
    chk("rstb_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.req = 2'b11;
    wait_gnt(n, ok);
    chk("rstb_first_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    wait_done(n, ok);
    chk("rstb_done_seen", ok, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
